fetch_insn_queue: RTL and testbench

Instruction queue between the fetch unit and the RISC-V decoder. Each entry holds one fetched 32-bit instruction, its PC, and the fetch-time branch prediction metadata. The head entry drives the decoder's instruction, PC, prediction, PHT-index and predicted-target inputs. The queue decouples fetch-side I-cache stalls from decode/allocate-side back-pressure and is emptied in one cycle on a pipeline flush.

---
 rtl/fetch_insn_queue.sv | 132 +++++++++++++
 tb/tb_fetch_insn_queue.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_insn_queue.sv
// Fetch-to-decode instruction queue: 2^LG_DEPTH circular buffer of
// fetched instructions, PCs and branch-prediction metadata.
//
// Ports:
//   clk, reset (sync, active-high), flush (drop all entries)
//   push_*   : fetch-side entry and valid/ready handshake
//   out_*    : head entry to decode, zero when out_valid=0
//   count    : occupancy 0..2^LG_DEPTH
//   full_cycles : cycles spent full since reset (wraps at 2^64)

`ifndef M_WIDTH
`define M_WIDTH 32
`endif
`ifndef LG_PHT_SZ
`define LG_PHT_SZ 10
`endif

module fetch_insn_queue #(
    parameter int LG_DEPTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  push_valid,
    output logic                  push_ready,
    input  logic [31:0]           push_insn,
    input  logic [`M_WIDTH-1:0]   push_pc,
    input  logic                  push_pred,
    input  logic [`LG_PHT_SZ-1:0] push_pht_idx,
    input  logic [`M_WIDTH-1:0]   push_pred_target,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_insn,
    output logic [`M_WIDTH-1:0]   out_pc,
    output logic                  out_pred,
    output logic [`LG_PHT_SZ-1:0] out_pht_idx,
    output logic [`M_WIDTH-1:0]   out_pred_target,
    output logic [LG_DEPTH:0]     count,
    output logic [63:0]           full_cycles
);

    localparam int DEPTH = 1 << LG_DEPTH;
    localparam logic [LG_DEPTH:0] PTR_ONE = {{LG_DEPTH{1'b0}}, 1'b1};

    logic [31:0]           insn_q [DEPTH];
    logic [`M_WIDTH-1:0]   pc_q   [DEPTH];
    logic                  pred_q [DEPTH];
    logic [`LG_PHT_SZ-1:0] pht_q  [DEPTH];
    logic [`M_WIDTH-1:0]   tgt_q  [DEPTH];

    logic [LG_DEPTH:0]   wr_ptr_q, wr_ptr_d;
    logic [LG_DEPTH:0]   rd_ptr_q, rd_ptr_d;
    logic [63:0]         full_cycles_q, full_cycles_d;
    logic [LG_DEPTH-1:0] wr_idx, rd_idx;
    logic                empty, full;
    logic                push_fire, pop_fire;

    always_comb begin
        wr_idx    = wr_ptr_q[LG_DEPTH-1:0];
        rd_idx    = rd_ptr_q[LG_DEPTH-1:0];
        empty     = (wr_ptr_q == rd_ptr_q);
        // Same slot but different lap: writer is a full buffer ahead.
        full      = (wr_idx == rd_idx) &&
                    (wr_ptr_q[LG_DEPTH] != rd_ptr_q[LG_DEPTH]);
        push_fire = push_valid && !full;
        pop_fire  = out_ready && !empty;
    end

    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        full_cycles_d = full_cycles_q;
        if (full) begin
            full_cycles_d = full_cycles_q + 64'd1;
        end
        if (flush) begin
            // Redirect wins over any handshake completing this cycle.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_fire) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop_fire) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            full_cycles_q <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            full_cycles_q <= full_cycles_d;
        end
    end

    // Entry storage is left unreset; the output mask hides stale data.
    always_ff @(posedge clk) begin
        if (push_fire && !flush && !reset) begin
            insn_q[wr_idx] <= push_insn;
            pc_q[wr_idx]   <= push_pc;
            pred_q[wr_idx] <= push_pred;
            pht_q[wr_idx]  <= push_pht_idx;
            tgt_q[wr_idx]  <= push_pred_target;
        end
    end

    always_comb begin
        push_ready      = !full;
        out_valid       = !empty;
        count           = wr_ptr_q - rd_ptr_q;
        full_cycles     = full_cycles_q;
        out_insn        = '0;
        out_pc          = '0;
        out_pred        = 1'b0;
        out_pht_idx     = '0;
        out_pred_target = '0;
        if (!empty) begin
            out_insn        = insn_q[rd_idx];
            out_pc          = pc_q[rd_idx];
            out_pred        = pred_q[rd_idx];
            out_pht_idx     = pht_q[rd_idx];
            out_pred_target = tgt_q[rd_idx];
        end
    end

endmodule

// File: tb/tb_fetch_insn_queue.sv
// Self-checking bench for fetch_insn_queue using a queue scoreboard
// that mirrors expected occupancy, ordering and full-cycle count.

`ifndef M_WIDTH
`define M_WIDTH 32
`endif
`ifndef LG_PHT_SZ
`define LG_PHT_SZ 10
`endif

module tb_fetch_insn_queue;

    localparam int LG_DEPTH = 3;
    localparam int DEPTH = 1 << LG_DEPTH;

    typedef struct packed {
        logic [31:0]           insn;
        logic [`M_WIDTH-1:0]   pc;
        logic                  pred;
        logic [`LG_PHT_SZ-1:0] pht;
        logic [`M_WIDTH-1:0]   tgt;
    } entry_t;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  flush = 1'b0;
    logic                  push_valid = 1'b0;
    logic                  push_ready;
    logic [31:0]           push_insn = '0;
    logic [`M_WIDTH-1:0]   push_pc = '0;
    logic                  push_pred = 1'b0;
    logic [`LG_PHT_SZ-1:0] push_pht_idx = '0;
    logic [`M_WIDTH-1:0]   push_pred_target = '0;
    logic                  out_valid;
    logic                  out_ready = 1'b0;
    logic [31:0]           out_insn;
    logic [`M_WIDTH-1:0]   out_pc;
    logic                  out_pred;
    logic [`LG_PHT_SZ-1:0] out_pht_idx;
    logic [`M_WIDTH-1:0]   out_pred_target;
    logic [LG_DEPTH:0]     count;
    logic [63:0]           full_cycles;

    entry_t      sb[$];
    logic [63:0] exp_fc = '0;
    int          n_cmp = 0;
    int          n_err = 0;

    fetch_insn_queue #(.LG_DEPTH(LG_DEPTH)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .push_valid(push_valid), .push_ready(push_ready),
        .push_insn(push_insn), .push_pc(push_pc),
        .push_pred(push_pred), .push_pht_idx(push_pht_idx),
        .push_pred_target(push_pred_target),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_insn(out_insn), .out_pc(out_pc), .out_pred(out_pred),
        .out_pht_idx(out_pht_idx), .out_pred_target(out_pred_target),
        .count(count), .full_cycles(full_cycles)
    );

    always #5 clk = ~clk;

    task automatic set_push(input logic v, input logic [31:0] insn,
                            input logic [`M_WIDTH-1:0] pc);
        push_valid       = v;
        push_insn        = insn;
        push_pc          = pc;
        push_pred        = 1'b0;
        push_pht_idx     = '0;
        push_pred_target = '0;
    endtask

    // Advance one clock, updating the scoreboard from the bench's own
    // view of occupancy (never from DUT outputs).
    task automatic tick();
        entry_t e;
        int     sz;
        bit     pf, pp;
        sz = sb.size();
        pf = push_valid && (sz < DEPTH);
        pp = out_ready && (sz > 0);
        e  = '{push_insn, push_pc, push_pred, push_pht_idx,
               push_pred_target};
        @(posedge clk);
        if (reset) begin
            exp_fc = '0;
            sb.delete();
        end else begin
            if (sz == DEPTH) exp_fc = exp_fc + 64'd1;
            if (flush) begin
                sb.delete();
            end else begin
                if (pp) void'(sb.pop_front());
                if (pf) sb.push_back(e);
            end
        end
        #1;
    endtask

    task automatic drain();
        set_push(1'b0, '0, '0);
        out_ready = 1'b1;
        for (int i = 0; i < 2 * DEPTH && sb.size() > 0; i++) tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_out_valid got %b exp 0", out_valid);
        end
        n_cmp++;
        if (push_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_push_ready got %b exp 1", push_ready);
        end
        n_cmp++;
        if (count !== 4'd0) begin
            n_err++;
            $display("FAIL reset_count got %0d exp 0", count);
        end
        n_cmp++;
        if (full_cycles !== 64'd0) begin
            n_err++;
            $display("FAIL reset_full_cycles got %0d exp 0", full_cycles);
        end
        n_cmp++;
        if (out_insn !== 32'd0 || out_pc !== '0) begin
            n_err++;
            $display("FAIL reset_out_data got %h/%h exp 0", out_insn, out_pc);
        end
    endtask

    task automatic test_fill_drain();
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            set_push(1'b1, 32'h13 + i, `M_WIDTH'(32'h1000 + 4 * i));
            tick();
            n_cmp++;
            if (count !== sb.size() || count !== i + 1) begin
                n_err++;
                $display("FAIL fill_count got %0d exp %0d", count, i + 1);
            end
        end
        n_cmp++;
        if (push_ready !== 1'b0) begin
            n_err++;
            $display("FAIL full_push_ready got %b exp 0", push_ready);
        end
        for (int i = 0; i < 3; i++) begin
            set_push(1'b1, 32'hdead0000 + i, `M_WIDTH'(32'h9000));
            tick();
            n_cmp++;
            if (count !== 4'd8) begin
                n_err++;
                $display("FAIL ninth_push_count got %0d exp 8", count);
            end
            n_cmp++;
            if (full_cycles !== exp_fc || full_cycles !== 64'(i + 1)) begin
                n_err++;
                $display("FAIL full_cycles got %0d exp %0d",
                         full_cycles, exp_fc);
            end
        end
        set_push(1'b0, '0, '0);
        out_ready = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            n_cmp++;
            if (out_valid !== 1'b1 || out_pc !== sb[0].pc ||
                out_pc !== `M_WIDTH'(32'h1000 + 4 * k) ||
                out_insn !== sb[0].insn) begin
                n_err++;
                $display("FAIL drain_order got v=%b pc=%h exp pc=%h",
                         out_valid, out_pc, 32'h1000 + 4 * k);
            end
            tick();
        end
        out_ready = 1'b0;
        n_cmp++;
        if (count !== 4'd0 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL drain_empty got count=%0d v=%b exp 0/0",
                     count, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_push(1'b1, 32'h100 + i, `M_WIDTH'(32'h4000 + 4 * i));
            tick();
        end
        out_ready = 1'b1;
        for (int i = 3; i < 23; i++) begin
            set_push(1'b1, 32'h100 + i, `M_WIDTH'(32'h4000 + 4 * i));
            n_cmp++;
            if (out_pc !== sb[0].pc || out_insn !== sb[0].insn ||
                out_insn !== 32'h100 + i - 3) begin
                n_err++;
                $display("FAIL b2b_order got %h exp %h",
                         out_insn, 32'h100 + i - 3);
            end
            tick();
            n_cmp++;
            if (count !== 4'd3) begin
                n_err++;
                $display("FAIL b2b_count got %0d exp 3", count);
            end
        end
        drain();
    endtask

    task automatic test_full_empty_simul();
        set_push(1'b1, 32'h55, `M_WIDTH'(32'h5000));
        out_ready = 1'b1;
        tick();
        n_cmp++;
        if (count !== 4'd1 || out_insn !== 32'h55) begin
            n_err++;
            $display("FAIL empty_simul got count=%0d insn=%h exp 1/55",
                     count, out_insn);
        end
        out_ready = 1'b0;
        for (int i = 1; i < DEPTH; i++) begin
            set_push(1'b1, 32'h55 + i, `M_WIDTH'(32'h5000 + 4 * i));
            tick();
        end
        set_push(1'b1, 32'hbad, `M_WIDTH'(32'h6000));
        out_ready = 1'b1;
        n_cmp++;
        if (push_ready !== 1'b0) begin
            n_err++;
            $display("FAIL full_simul_ready got %b exp 0", push_ready);
        end
        tick();
        n_cmp++;
        if (count !== 4'd7 || out_insn !== 32'h56) begin
            n_err++;
            $display("FAIL full_simul got count=%0d insn=%h exp 7/56",
                     count, out_insn);
        end
        drain();
    endtask

    task automatic test_flush();
        logic [63:0] fc_before;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_push(1'b1, 32'h700 + i, `M_WIDTH'(32'h7000 + 4 * i));
            tick();
        end
        fc_before = exp_fc;
        set_push(1'b1, 32'h7ff, `M_WIDTH'(32'h7ffc));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_cmp++;
        if (count !== 4'd0 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL flush_empty got count=%0d v=%b exp 0/0",
                     count, out_valid);
        end
        n_cmp++;
        if (full_cycles !== fc_before) begin
            n_err++;
            $display("FAIL flush_full_cycles got %0d exp %0d",
                     full_cycles, fc_before);
        end
        set_push(1'b1, 32'h800, `M_WIDTH'(32'h8000));
        tick();
        set_push(1'b0, '0, '0);
        n_cmp++;
        if (out_valid !== 1'b1 || count !== 4'd1 || out_insn !== 32'h800) begin
            n_err++;
            $display("FAIL post_flush_push got v=%b c=%0d insn=%h exp 1/1/800",
                     out_valid, count, out_insn);
        end
        drain();
    endtask

    task automatic test_metadata();
        out_ready        = 1'b0;
        push_valid       = 1'b1;
        push_insn        = 32'h00008067;
        push_pc          = `M_WIDTH'(32'h3000);
        push_pred        = 1'b1;
        push_pht_idx     = '1;
        push_pred_target = `M_WIDTH'(32'h2040);
        tick();
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (out_insn !== 32'h00008067 || out_pred !== 1'b1 ||
                out_pht_idx !== {`LG_PHT_SZ{1'b1}} ||
                out_pred_target !== `M_WIDTH'(32'h2040) ||
                out_pc !== `M_WIDTH'(32'h3000) || out_insn !== sb[0].insn) begin
                n_err++;
                $display("FAIL meta_hold%0d got %h %b %h %h", i,
                         out_insn, out_pred, out_pht_idx, out_pred_target);
            end
            set_push(1'b1, 32'ha00 + i, `M_WIDTH'(32'ha000 + 4 * i));
            if (i < 4) tick();
        end
        drain();
        n_cmp++;
        if (count !== 4'd0) begin
            n_err++;
            $display("FAIL meta_drain got %0d exp 0", count);
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_back_to_back();
        test_full_empty_simul();
        test_flush();
        test_metadata();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
